// File: rtl/hs_4ph_to_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : hs_4ph_to_stream_if
// Brief    : 4-phase req/ack input side and valid/ready stream output side
// Revision : 1.0
// ============================================================================
interface hs_4ph_to_stream_if #(
    parameter int DW    = 8,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          req_i;
    logic [DW-1:0] data_i;
    logic          ack_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic [CW-1:0] count_o;

    modport master (
        output req_i, data_i, out_ready_i,
        input  ack_o, out_valid_o, out_data_o, count_o
    );

    modport slave (
        input  req_i, data_i, out_ready_i,
        output ack_o, out_valid_o, out_data_o, count_o
    );
endinterface
`default_nettype wire

// File: rtl/hs_4ph_to_stream.sv
`default_nettype none
// ============================================================================
// Module   : hs_4ph_to_stream
// Brief    : 4-phase bundled-data producer to clocked valid/ready stream via FIFO
// Revision : 1.0
// ============================================================================
module hs_4ph_to_stream #(
    parameter int DW          = 8,
    parameter int DEPTH       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    hs_4ph_to_stream_if.slave  bus
);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_req_s;
    logic              w_wr;
    logic              w_rd;
    logic              w_not_full;
    logic [c_PW-1:0]   r_wr_ptr;
    logic [c_PW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;
    logic [DW-1:0]     r_mem [DEPTH];

    function automatic logic [c_PW-1:0] f_inc(input logic [c_PW-1:0] p);
        return (p == c_PW'(DEPTH - 1)) ? '0 : p + c_PW'(1);
    endfunction

    // SYNC_STAGES=0 treats req_i as an already-synchronous input
    if (SYNC_STAGES > 0) begin : g_sync
        logic [SYNC_STAGES-1:0] r_sync;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync <= '0;
            end else begin
                r_sync[0] <= bus.req_i;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    r_sync[i] <= r_sync[i-1];
                end
            end
        end
        assign w_req_s = r_sync[SYNC_STAGES-1];
    end else begin : g_nosync
        assign w_req_s = bus.req_i;
    end

    assign w_not_full = (r_count < c_CW'(DEPTH));
    assign w_rd       = (r_count != '0) && bus.out_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture happens on the IDLE->ACK edge; a full FIFO holds off ack
    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_s && w_not_full) begin
                    w_wr        = 1'b1;
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!w_req_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= f_inc(r_wr_ptr);
            end
            if (w_rd) begin
                r_rd_ptr <= f_inc(r_rd_ptr);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= bus.data_i;
        end
    end

    assign bus.ack_o       = (r_state == ST_ACK);
    assign bus.out_valid_o = (r_count != '0);
    assign bus.out_data_o  = r_mem[r_rd_ptr];
    assign bus.count_o     = r_count;
endmodule
`default_nettype wire

// File: tb/tb_hs_4ph_to_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_hs_4ph_to_stream
// Brief    : scoreboard bench for hs_4ph_to_stream (three configurations)
// Revision : 1.0
// ============================================================================
module tb_hs_4ph_to_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   max1    = 0;
    bit   done1   = 1'b0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    always #5 clk = ~clk;

    hs_4ph_to_stream_if #(.DW(8), .DEPTH(2)) if0 ();
    hs_4ph_to_stream_if #(.DW(8), .DEPTH(3)) if1 ();
    hs_4ph_to_stream_if #(.DW(8), .DEPTH(2)) if2 ();

    hs_4ph_to_stream #(.DW(8), .DEPTH(2), .SYNC_STAGES(2)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    hs_4ph_to_stream #(.DW(8), .DEPTH(3), .SYNC_STAGES(2)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    hs_4ph_to_stream #(.DW(8), .DEPTH(2), .SYNC_STAGES(0)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: a pop happens at the next rising edge
    always @(negedge clk) begin
        if (!rst && if0.out_valid_o && if0.out_ready_i) begin
            if (q0.size() == 0) check("pop0_unexpected", 32'(if0.out_data_o), 32'hFFFF_FFFF);
            else                check("pop0_data", 32'(if0.out_data_o), 32'(q0.pop_front()));
        end
        if (!rst && if1.out_valid_o && if1.out_ready_i) begin
            if (q1.size() == 0) check("pop1_unexpected", 32'(if1.out_data_o), 32'hFFFF_FFFF);
            else                check("pop1_data", 32'(if1.out_data_o), 32'(q1.pop_front()));
        end
        if (!rst && if2.out_valid_o && if2.out_ready_i) begin
            if (q2.size() == 0) check("pop2_unexpected", 32'(if2.out_data_o), 32'hFFFF_FFFF);
            else                check("pop2_data", 32'(if2.out_data_o), 32'(q2.pop_front()));
        end
        if (int'(if1.count_o) > max1) max1 = int'(if1.count_o);
    end

    task automatic wait_ack0(input logic v, input string name);
        int n = 0;
        while (if0.ack_o !== v && n < 50) begin tick(); n++; end
        check(name, 32'(if0.ack_o), 32'(v));
    endtask

    task automatic wait_ack1(input logic v, input string name);
        int n = 0;
        while (if1.ack_o !== v && n < 50) begin tick(); n++; end
        check(name, 32'(if1.ack_o), 32'(v));
    endtask

    task automatic send0(input logic [7:0] d);
        if0.data_i = d;
        if0.req_i  = 1'b1;
        q0.push_back(d);
        wait_ack0(1'b1, "send0_ack_rise");
        if0.req_i = 1'b0;
        wait_ack0(1'b0, "send0_ack_fall");
    endtask

    task automatic send1(input logic [7:0] d);
        if1.data_i = d;
        if1.req_i  = 1'b1;
        q1.push_back(d);
        wait_ack1(1'b1, "send1_ack_rise");
        if1.req_i = 1'b0;
        wait_ack1(1'b0, "send1_ack_fall");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        if0.req_i = 1'b0; if0.data_i = 8'h00; if0.out_ready_i = 1'b0;
        if1.req_i = 1'b0; if1.data_i = 8'h00; if1.out_ready_i = 1'b0;
        if2.req_i = 1'b0; if2.data_i = 8'h00; if2.out_ready_i = 1'b0;

        // Reset and idle
        tick(); tick();
        rst = 1'b0;
        repeat (5) tick();
        check("rst_ack0",   32'(if0.ack_o),       32'd0);
        check("rst_valid0", 32'(if0.out_valid_o), 32'd0);
        check("rst_count0", 32'(if0.count_o),     32'd0);
        check("rst_count1", 32'(if1.count_o),     32'd0);

        // Single transfer, two-stage synchroniser latency
        if0.out_ready_i = 1'b1;
        if0.data_i = 8'hA5;
        if0.req_i  = 1'b1;
        q0.push_back(8'hA5);
        tick();
        check("lat_e0_ack", 32'(if0.ack_o), 32'd0);
        tick();
        check("lat_e1_valid", 32'(if0.out_valid_o), 32'd0);
        tick();
        check("lat_e2_ack",   32'(if0.ack_o),       32'd1);
        check("lat_e2_valid", 32'(if0.out_valid_o), 32'd1);
        check("lat_e2_data",  32'(if0.out_data_o),  32'hA5);
        check("lat_e2_count", 32'(if0.count_o),     32'd1);
        tick();
        check("lat_e3_count", 32'(if0.count_o), 32'd0);
        if0.req_i = 1'b0;
        tick();
        check("rel_f0_ack", 32'(if0.ack_o), 32'd1);
        tick();
        check("rel_f1_ack", 32'(if0.ack_o), 32'd1);
        tick();
        check("rel_f2_ack", 32'(if0.ack_o), 32'd0);

        // Backpressure on a full FIFO
        if0.out_ready_i = 1'b0;
        send0(8'h11);
        send0(8'h22);
        check("bp_count_full", 32'(if0.count_o), 32'd2);
        if0.data_i = 8'h33;
        if0.req_i  = 1'b1;
        q0.push_back(8'h33);
        repeat (5) tick();
        check("bp_ack_held",  32'(if0.ack_o),   32'd0);
        check("bp_count_hold", 32'(if0.count_o), 32'd2);
        if0.out_ready_i = 1'b1;
        tick();
        if0.out_ready_i = 1'b0;
        check("bp_pop_count", 32'(if0.count_o), 32'd1);
        check("bp_pop_ack",   32'(if0.ack_o),   32'd0);
        tick();
        check("bp_retry_count", 32'(if0.count_o), 32'd2);
        check("bp_retry_ack",   32'(if0.ack_o),   32'd1);
        if0.req_i = 1'b0;
        wait_ack0(1'b0, "bp_ack_fall");
        if0.out_ready_i = 1'b1;
        repeat (3) tick();
        if0.out_ready_i = 1'b0;
        check("bp_drain_count", 32'(if0.count_o), 32'd0);
        check("bp_drain_q",     32'(q0.size()),   32'd0);

        // Ordering and pointer wrap with DEPTH=3
        fork
            begin
                for (int i = 1; i <= 7; i++) send1(8'(i));
                done1 = 1'b1;
            end
            begin
                while (!done1) begin
                    if1.out_ready_i = ~if1.out_ready_i;
                    tick();
                end
            end
        join
        if1.out_ready_i = 1'b1;
        repeat (6) tick();
        if1.out_ready_i = 1'b0;
        check("wrap_drain_q",     32'(q1.size()),   32'd0);
        check("wrap_drain_count", 32'(if1.count_o), 32'd0);
        check("wrap_max_le3",     32'(max1 <= 3),   32'd1);

        // Reset in the middle of a handshake with req held high
        send0(8'h44);
        if0.data_i = 8'h55;
        if0.req_i  = 1'b1;
        q0.push_back(8'h55);
        wait_ack0(1'b1, "mid_ack_rise");
        check("mid_count_pre", 32'(if0.count_o), 32'd2);
        rst = 1'b1;
        tick();
        check("mid_rst_count", 32'(if0.count_o),     32'd0);
        check("mid_rst_ack",   32'(if0.ack_o),       32'd0);
        check("mid_rst_valid", 32'(if0.out_valid_o), 32'd0);
        q0.delete();
        rst = 1'b0;
        if0.data_i = 8'h66;
        q0.push_back(8'h66);
        repeat (3) tick();
        check("mid_recap_count", 32'(if0.count_o),    32'd1);
        check("mid_recap_ack",   32'(if0.ack_o),      32'd1);
        check("mid_recap_data",  32'(if0.out_data_o), 32'h66);
        if0.req_i = 1'b0;
        wait_ack0(1'b0, "mid_ack_fall");
        if0.out_ready_i = 1'b1;
        repeat (2) tick();
        if0.out_ready_i = 1'b0;
        check("mid_drain_q", 32'(q0.size()), 32'd0);

        // No synchroniser: capture on the first sampling edge
        if2.data_i = 8'h5A;
        if2.req_i  = 1'b1;
        q2.push_back(8'h5A);
        check("s0_pre_ack", 32'(if2.ack_o), 32'd0);
        tick();
        check("s0_e0_ack",   32'(if2.ack_o),      32'd1);
        check("s0_e0_count", 32'(if2.count_o),    32'd1);
        check("s0_e0_data",  32'(if2.out_data_o), 32'h5A);
        if2.req_i = 1'b0;
        tick();
        check("s0_rel_ack", 32'(if2.ack_o), 32'd0);
        if2.out_ready_i = 1'b1;
        repeat (2) tick();
        check("s0_drain_q",     32'(q2.size()),   32'd0);
        check("s0_drain_count", 32'(if2.count_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
